scan_ctrl: RTL
==============

Name: scan_ctrl

Overview:
- Multiplexed 7-segment display controller.
- Time-multiplexes up to 8 hex digits onto a shared digit-select/segment bus.
- Prescaler sets the scan rate.
- Double-buffered digit registers: writers fill a shadow bank; a commit request copies it to the active bank only at a frame boundary, so the display never tears.
- Sits between counter/datapath blocks and the board's digit-select and segment pins.

Parameters:
- DIV, 50000, clk cycles per digit slot; legal range ≥ 2.
- NDIG, 8, number of digits scanned; legal range 1..8.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  display enable; low forces seg to 0.
- wr_valid  input  1  shadow write request.
- wr_ready  output  1  shadow bank accepting writes.
- wr_addr  input  3  digit index; 0 is least significant.
- wr_data  input  5  digit value as {dp, hex[3:0]}.
- commit  input  1  request to copy shadow to active at the next frame boundary.
- commit_ack  output  1  one-cycle pulse on the cycle the copy occurs.
- sel  output  3  current digit index.
- seg  output  8  segment drive {dp,g,f,e,d,c,b,a}, active high.

Behaviour:
- Reset (async, immediate): prescaler cnt=0, sel=0, seg=0, all shadow and active digits=0, pending=0, commit_ack=0, wr_ready=1.
- Prescaler:
  - cnt counts 0..DIV-1 and wraps to 0.
  - tick is asserted while cnt==DIV-1.
- Scan:
  - On a tick edge, sel advances by 1, wrapping from NDIG-1 to 0. Otherwise sel holds.
  - sel never takes values ≥ NDIG.
  - NDIG=1 keeps sel=0; every tick is then a frame boundary.
- Frame boundary = tick while sel==NDIG-1.
- Write handshake:
  - A write is accepted when wr_valid && wr_ready; shadow[wr_addr] <= wr_data.
  - wr_addr ≥ NDIG is accepted but discarded.
  - wr_ready = !pending (combinational).
- Commit:
  - commit while !pending sets pending. commit while pending is ignored.
  - A write and a commit in the same cycle: the write is accepted and included in the commit.
  - At a frame-boundary edge with pending=1: active <= shadow, pending <= 0, commit_ack=1 for that one cycle.
  - A commit raised in the same cycle as a boundary is applied at the following boundary, not the current one.
- Shadow retains its contents after a commit; it is not cleared.
- Segment output:
  - seg is registered and updated every edge: seg <= en ? enc(active_next[sel_next]) : 8'h00. The _next terms are the values loaded on that same edge.
  - seg is therefore always consistent with sel. Digit 0 shows freshly committed data on the boundary edge.
  - Latency: en or a digit change reaches seg 1 cycle later.
- Encoding of {g..a}, hex 0-F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71. seg[7] = dp bit.
- Mid-operation reset: all state is cleared immediately, including any pending commit.
- rst deasserting restarts the scan at sel=0 with cnt=0.

Optional Feature:
- Macro: SCAN_LZ_BLANK_EN.
- When defined, leading-zero blanking applies:
  - A digit i > 0 displays seg=0 when it and every active digit above it (up to NDIG-1) have hex==0 and dp==0.
  - Digit 0 is never blanked.
  - Blanking is evaluated on the active bank; timing is the same 1-cycle latency.
- When undefined, every digit is decoded normally, so a zero shows 3F.

Test Plan:
- Reset/scan: DIV=4, NDIG=8, rst pulse mid-count -> sel=0, seg=0 immediately; afterwards sel steps 0→1→…→7→0 every 4 cycles.
- Write+commit:
  - Stimulus: write digits 0..7 = 0..7, pulse commit.
  - Required: wr_ready=0 until the boundary; commit_ack pulses once as sel wraps to 0.
  - Required: seg then reads 3F,06,5B,4F,66,6D,7D,07 per slot.
- Tear-free: write 5'h1F to digit 3 without commit -> display unchanged for ≥2 frames; after commit + boundary, digit 3 shows F1.
- Boundary collision:
  - Stimulus: commit asserted in the boundary cycle.
  - Required: no copy at that boundary; copy and commit_ack occur at the next boundary, DIV*NDIG cycles later.
  - Stimulus: second commit while pending. Required: ignored, only one ack.
- Disable/invalid addr:
  - Stimulus: en=0. Required: seg=00 one cycle later while sel continues scanning.
  - Stimulus: write to addr 7 with NDIG=4. Required: accepted, no visible effect, sel never exceeds 3.
- SCAN_LZ_BLANK_EN: active = 0,0,0,0,0,0,1,2 (digit7..0 = 0,0,0,0,0,0,1,2) -> digits 7..2 seg=00, digit1=06, digit0=5B; all-zero value -> only digit 0 shows 3F.

Source files
------------

// File: rtl/scan_ctrl.sv
// Multiplexed 7-segment scanner with double-buffered digit banks and frame-aligned commit.
// Optional leading-zero blanking is enabled by defining SCAN_LZ_BLANK_EN.
module scan_ctrl #(
  parameter int DIV  = 50000,
  parameter int NDIG = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic       commit,
  output logic       commit_ack,
  output logic [2:0] sel,
  output logic [7:0] seg
);

  localparam int             CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);
  localparam logic [2:0]     SEL_LAST = 3'(NDIG - 1);

  logic [CW-1:0] cnt;
  logic          pending;
  logic [4:0]    shadow [8];
  logic [4:0]    active [8];

  logic          tick;
  logic          boundary;
  logic          copy;
  logic [2:0]    sel_next;
  logic [4:0]    src [8];
  logic [4:0]    digit;
  logic [7:0]    seg_next;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] enc(input logic [4:0] d);
    enc = {d[4], hex7(d[3:0])};
  endfunction

  assign tick     = (cnt == CNT_LAST);
  assign boundary = tick && (sel == SEL_LAST);
  assign copy     = boundary && pending;
  assign wr_ready = !pending;

  always_comb begin
    sel_next = sel;
    if (tick) begin
      if (sel == SEL_LAST) sel_next = 3'd0;
      else                 sel_next = sel + 3'd1;
    end
  end

  // seg must reflect the bank as it will be after this edge, so a copy is looked through
  always_comb begin
    for (int i = 0; i < 8; i++) src[i] = copy ? shadow[i] : active[i];
  end

  assign digit = src[sel_next];

`ifdef SCAN_LZ_BLANK_EN
  logic blank;

  always_comb begin
    blank = (sel_next != 3'd0);
    for (int i = 0; i < 8; i++) begin
      if (i < NDIG && i >= int'(sel_next) && src[i] != 5'd0) blank = 1'b0;
    end
  end

  always_comb begin
    seg_next = 8'h00;
    if (en && !blank) seg_next = enc(digit);
  end
`else
  always_comb begin
    seg_next = 8'h00;
    if (en) seg_next = enc(digit);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      sel        <= 3'd0;
      seg        <= 8'h00;
      pending    <= 1'b0;
      commit_ack <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + CW'(1);
      sel        <= sel_next;
      seg        <= seg_next;
      commit_ack <= copy;
      // a commit landing on the copying boundary is dropped because pending is still set
      if (copy)        pending <= 1'b0;
      else if (commit) pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= 5'd0;
        active[i] <= 5'd0;
      end
    end else begin
      if (wr_valid && wr_ready && int'(wr_addr) < NDIG) shadow[wr_addr] <= wr_data;
      if (copy) begin
        for (int i = 0; i < 8; i++) active[i] <= shadow[i];
      end
    end
  end

endmodule
